// File: rtl/icon_fetch_ctrl_if.sv
// Signal bundle between the icon fetch controller, the bot/DTG sources, the icon ROM bank
// and the colorizer. The controller uses the slave view; the environment drives the master view.
interface icon_fetch_ctrl_if;
    logic       frame_start;
    logic [7:0] LocX;
    logic [7:0] LocY;
    logic [7:0] BotInfo;
    logic [9:0] pixel_row;
    logic [9:0] pixel_column;
    logic [1:0] rom_sel;
    logic [7:0] rom_addr;
    logic [1:0] rom_data;
    logic [1:0] icon;
    logic [8:0] hit_count;
    logic       running;

    modport master (
        output frame_start, LocX, LocY, BotInfo, pixel_row, pixel_column, rom_data,
        input  rom_sel, rom_addr, icon, hit_count, running
    );

    modport slave (
        input  frame_start, LocX, LocY, BotInfo, pixel_row, pixel_column, rom_data,
        output rom_sel, rom_addr, icon, hit_count, running
    );
endinterface

// File: rtl/icon_fetch_ctrl.sv
// Rojobot icon fetch controller: per-frame shadowing of bot pose, ROM select/address
// generation with 180-degree rotation by address inversion, and per-frame hit counting.
module icon_fetch_ctrl #(
    parameter int unsigned ICON_SIZE   = 16,
    parameter int unsigned X_SCALE_SH  = 3,
    parameter int unsigned Y_SCALE     = 6,
    parameter int unsigned ROM_LATENCY = 1
) (
    input logic               clock,
    input logic               reset,
    icon_fetch_ctrl_if.slave  bus
);

    localparam int unsigned OffW = $clog2(ICON_SIZE);

    typedef enum logic [0:0] {StWaitFrame, StRun} state_e;

    state_e                 state_q, state_d;
    logic [7:0]             locx_q, locx_d;
    logic [7:0]             locy_q, locy_d;
    logic [2:0]             orient_q, orient_d;
    logic [1:0]             rom_sel_q, rom_sel_d;
    logic [7:0]             rom_addr_q, rom_addr_d;
    logic [ROM_LATENCY-1:0] hit_pipe_q, hit_pipe_d;
    logic [1:0]             icon_q, icon_d;
    logic [8:0]             cnt_q, cnt_d;
    logic [8:0]             hit_count_q, hit_count_d;

    logic [11:0]       org_x, org_y, row_ext, col_ext;
    logic [OffW-1:0]   row_off, col_off;
    logic [2*OffW-1:0] lin;
    logic              hit, out_hit;
    logic [1:0]        sel;
    logic              inv;

    logic unused_botinfo;
    assign unused_botinfo = ^bus.BotInfo[7:3];

    // Box geometry from the shadowed pose; 12 bits is wide enough that nothing wraps.
    always_comb begin
        org_x   = {4'b0, locx_q} << X_SCALE_SH;
        org_y   = {4'b0, locy_q} * 12'(Y_SCALE);
        row_ext = {2'b0, bus.pixel_row};
        col_ext = {2'b0, bus.pixel_column};
        hit     = (row_ext >= org_y) && (row_ext <= org_y + 12'(ICON_SIZE - 1)) &&
                  (col_ext >= org_x) && (col_ext <= org_x + 12'(ICON_SIZE - 1));
        row_off = row_ext[OffW-1:0] - org_y[OffW-1:0];
        col_off = col_ext[OffW-1:0] - org_x[OffW-1:0];
        lin     = {row_off, col_off};
    end

    // Opposite headings share one image; the second of each pair reads it inverted.
    always_comb begin
        sel = 2'd0;
        inv = 1'b0;
        unique case (orient_q)
            3'b000: begin sel = 2'd0; inv = 1'b0; end
            3'b100: begin sel = 2'd0; inv = 1'b1; end
            3'b010: begin sel = 2'd1; inv = 1'b0; end
            3'b110: begin sel = 2'd1; inv = 1'b1; end
            3'b001: begin sel = 2'd2; inv = 1'b0; end
            3'b101: begin sel = 2'd2; inv = 1'b1; end
            3'b111: begin sel = 2'd3; inv = 1'b0; end
            3'b011: begin sel = 2'd3; inv = 1'b1; end
            default: begin sel = 2'd0; inv = 1'b0; end
        endcase
    end

    always_comb begin
        state_d     = state_q;
        locx_d      = locx_q;
        locy_d      = locy_q;
        orient_d    = orient_q;
        rom_sel_d   = rom_sel_q;
        rom_addr_d  = rom_addr_q;
        hit_count_d = hit_count_q;
        cnt_d       = cnt_q;

        hit_pipe_d[0] = hit;
        for (int unsigned i = 1; i < ROM_LATENCY; i++) begin
            hit_pipe_d[i] = hit_pipe_q[i-1];
        end

        out_hit = hit_pipe_q[ROM_LATENCY-1] && (state_q == StRun);
        icon_d  = out_hit ? bus.rom_data : 2'd0;

        if (hit) begin
            rom_sel_d  = sel;
            rom_addr_d = inv ? 8'(~lin) : 8'(lin);
        end

        // Frame boundary wins over a same-cycle increment.
        if (bus.frame_start) begin
            hit_count_d = cnt_q;
            cnt_d       = 9'd0;
        end else if (out_hit && (cnt_q != 9'd511)) begin
            cnt_d = cnt_q + 9'd1;
        end

        if (bus.frame_start) begin
            locx_d   = bus.LocX;
            locy_d   = bus.LocY;
            orient_d = bus.BotInfo[2:0];
        end

        unique case (state_q)
            StWaitFrame: if (bus.frame_start) state_d = StRun;
            StRun:       state_d = StRun;
            default:     state_d = StWaitFrame;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= StWaitFrame;
            locx_q      <= '0;
            locy_q      <= '0;
            orient_q    <= '0;
            rom_sel_q   <= '0;
            rom_addr_q  <= '0;
            hit_pipe_q  <= '0;
            icon_q      <= '0;
            cnt_q       <= '0;
            hit_count_q <= '0;
        end else begin
            state_q     <= state_d;
            locx_q      <= locx_d;
            locy_q      <= locy_d;
            orient_q    <= orient_d;
            rom_sel_q   <= rom_sel_d;
            rom_addr_q  <= rom_addr_d;
            hit_pipe_q  <= hit_pipe_d;
            icon_q      <= icon_d;
            cnt_q       <= cnt_d;
            hit_count_q <= hit_count_d;
        end
    end

    assign bus.rom_sel   = rom_sel_q;
    assign bus.rom_addr  = rom_addr_q;
    assign bus.icon      = icon_q;
    assign bus.hit_count = hit_count_q;
    assign bus.running   = (state_q == StRun);

endmodule

// File: tb/tb_icon_fetch_ctrl.sv
// Bench for icon_fetch_ctrl: directed and randomized pixel streams checked every clock
// against a pixel-level reference model of the icon overlay.
module tb_icon_fetch_ctrl;

    logic clock;
    logic reset;
    int   checks;
    int   errors;

    icon_fetch_ctrl_if bus ();

    icon_fetch_ctrl #(
        .ICON_SIZE   (16),
        .X_SCALE_SH  (3),
        .Y_SCALE     (6),
        .ROM_LATENCY (1)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [1:0] rom_fn(input logic [1:0] s, input logic [7:0] a);
        int v;
        v = int'(a) * 5 + int'(s) * 3 + int'(a >> 3);
        return v[1:0];
    endfunction

    // Image bank answers in the cycle the registered address is presented.
    assign bus.rom_data = rom_fn(bus.rom_sel, bus.rom_addr);

    // Reference model state
    int m_locx, m_locy, m_orient, m_cnt, m_hc, m_sel, m_addr, m_icon;
    bit m_run, m_dhit;
    int sel_tab [8] = '{0, 2, 1, 3, 0, 2, 1, 3};
    int inv_tab [8] = '{0, 0, 0, 1, 1, 1, 1, 0};

    task automatic model_reset();
        m_locx = 0; m_locy = 0; m_orient = 0; m_cnt = 0; m_hc = 0;
        m_sel = 0; m_addr = 0; m_icon = 0; m_run = 0; m_dhit = 0;
    endtask

    task automatic model_edge();
        int r, c, ox, oy, a, nicon;
        bit hit;
        r   = int'(bus.pixel_row);
        c   = int'(bus.pixel_column);
        oy  = m_locy * 6;
        ox  = m_locx * 8;
        hit = (r >= oy) && (r < oy + 16) && (c >= ox) && (c < ox + 16);
        nicon = (m_dhit && m_run) ? int'(rom_fn(m_sel[1:0], m_addr[7:0])) : 0;
        if (bus.frame_start) begin
            m_hc  = m_cnt;
            m_cnt = 0;
        end else if (m_dhit && m_run && m_cnt < 511) begin
            m_cnt++;
        end
        if (hit) begin
            a      = (r - oy) * 16 + (c - ox);
            m_sel  = sel_tab[m_orient];
            m_addr = (inv_tab[m_orient] != 0) ? 255 - a : a;
        end
        m_dhit = hit;
        m_icon = nicon;
        if (bus.frame_start) begin
            m_locx   = int'(bus.LocX);
            m_locy   = int'(bus.LocY);
            m_orient = int'(bus.BotInfo[2:0]);
            m_run    = 1'b1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input int exp);
        checks++;
        assert (obs === 32'(exp))
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("icon", 32'(bus.icon), m_icon);
        chk("rom_sel", 32'(bus.rom_sel), m_sel);
        chk("rom_addr", 32'(bus.rom_addr), m_addr);
        chk("hit_count", 32'(bus.hit_count), m_hc);
        chk("running", 32'(bus.running), int'(m_run));
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        model_edge();
        check_all();
    endtask

    task automatic setpix(input int r, input int c);
        bus.pixel_row    = 10'(r);
        bus.pixel_column = 10'(c);
    endtask

    task automatic frame_pulse(input int lx, input int ly, input int info);
        bus.LocX        = 8'(lx);
        bus.LocY        = 8'(ly);
        bus.BotInfo     = 8'(info);
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
    endtask

    task automatic raster(input int r0, input int r1, input int c0, input int c1);
        for (int r = r0; r <= r1; r++) begin
            for (int c = c0; c <= c1; c++) begin
                setpix(r, c);
                tick();
            end
        end
        setpix(0, 1023);
        repeat (3) tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        bus.frame_start = 1'b0;
        bus.LocX = 8'd10; bus.LocY = 8'd10; bus.BotInfo = 8'd0;
        setpix(0, 1023);
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        check_all();
        #2 reset = 1'b1;

        // No frame_start yet: pixels over the box must stay transparent.
        for (int i = 0; i < 120; i++) begin
            setpix(int'($urandom_range(0, 80)), int'($urandom_range(0, 100)));
            tick();
        end
        chk("wait_running", 32'(bus.running), 0);
        chk("wait_icon", 32'(bus.icon), 0);

        // North, corner addresses
        setpix(0, 1023);
        frame_pulse(10, 10, 0);
        setpix(60, 80);
        tick();
        chk("n_sel_first", 32'(bus.rom_sel), 0);
        chk("n_addr_first", 32'(bus.rom_addr), 0);
        setpix(75, 95);
        tick();
        chk("n_icon_first", 32'(bus.icon), int'(rom_fn(2'd0, 8'd0)));
        chk("n_addr_last", 32'(bus.rom_addr), 255);
        setpix(0, 1023);
        tick();

        // Rotated orientations
        frame_pulse(10, 10, 3'b100);
        setpix(61, 82);
        tick();
        chk("s_sel", 32'(bus.rom_sel), 0);
        chk("s_addr", 32'(bus.rom_addr), 'hED);
        foreach (sel_tab[o]) begin
            setpix(0, 1023);
            frame_pulse(10, 10, o);
            for (int i = 0; i < 30; i++) begin
                setpix(int'($urandom_range(58, 77)), int'($urandom_range(78, 97)));
                tick();
            end
        end
        setpix(0, 1023);
        frame_pulse(10, 10, 3'b110);
        setpix(61, 82);
        tick();
        chk("w_sel", 32'(bus.rom_sel), 1);
        chk("w_addr", 32'(bus.rom_addr), 'hED);

        // Mid-frame orientation change waits for the next frame
        setpix(0, 1023);
        frame_pulse(10, 10, 0);
        bus.BotInfo = 8'b010;
        setpix(65, 85);
        tick();
        chk("mid_sel_hold", 32'(bus.rom_sel), 0);
        setpix(0, 1023);
        frame_pulse(10, 10, 3'b010);
        setpix(65, 85);
        tick();
        chk("mid_sel_new", 32'(bus.rom_sel), 1);
        setpix(0, 1023);
        tick();

        // Hit counting: full box, saturation, off-screen box
        frame_pulse(10, 10, 0);
        raster(50, 85, 70, 105);
        frame_pulse(10, 10, 0);
        chk("count_256", 32'(bus.hit_count), 256);
        for (int k = 0; k < 3; k++) raster(60, 75, 80, 95);
        frame_pulse(10, 80, 0);
        chk("count_sat", 32'(bus.hit_count), 511);
        raster(470, 479, 70, 105);
        frame_pulse(10, 10, 0);
        chk("count_offscreen", 32'(bus.hit_count), 0);

        // Randomized frames
        for (int f = 0; f < 30; f++) begin
            int lx, ly;
            lx = int'($urandom_range(0, 90));
            ly = int'($urandom_range(0, 85));
            frame_pulse(lx, ly, int'($urandom_range(0, 255)));
            for (int i = 0; i < 60; i++) begin
                int r, c;
                r = ly * 6 + int'($urandom_range(0, 21)) - 3;
                c = lx * 8 + int'($urandom_range(0, 21)) - 3;
                setpix(r < 0 ? 0 : r, c < 0 ? 0 : c);
                if ($urandom_range(0, 15) == 0) bus.BotInfo = 8'($urandom);
                tick();
            end
        end

        // Asynchronous reset in the middle of a hit run
        setpix(0, 1023);
        frame_pulse(10, 10, 3'b100);
        setpix(66, 87);
        repeat (3) tick();
        #2 reset = 1'b0;
        #1;
        model_reset();
        chk("rst_icon", 32'(bus.icon), 0);
        chk("rst_addr", 32'(bus.rom_addr), 0);
        chk("rst_running", 32'(bus.running), 0);
        @(posedge clock);
        #1;
        check_all();
        #2 reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            setpix(int'($urandom_range(60, 75)), int'($urandom_range(80, 95)));
            tick();
        end
        chk("post_rst_running", 32'(bus.running), 0);
        setpix(0, 1023);
        frame_pulse(10, 10, 0);
        chk("post_rst_run", 32'(bus.running), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
